// File: rtl/cache_ctrl_assoc_pkg.sv
// cache_ctrl_assoc_pkg: state encoding, default geometry and helpers shared by
// the set-associative cache controller and its way arrays.
package cache_ctrl_assoc_pkg;
    localparam logic [1:0] IDLE       = 2'b00;
    localparam logic [1:0] READ_MISS  = 2'b01;
    localparam logic [1:0] WRITE_THRU = 2'b10;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_SET_BITS = 6;
    localparam int TAG_W        = DEF_ADDR_W - 3 - DEF_SET_BITS;
    localparam int SETS         = 1 << DEF_SET_BITS;

    // 8-byte lines: 3 offset bits below the index, the remainder is tag
    function automatic int tag_width(input int addr_w, input int set_bits);
        return addr_w - 3 - set_bits;
    endfunction

    function automatic bit ways_legal(input int ways);
        return ways == 1 || ways == 2;
    endfunction
endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: one way of the cache - valid/tag/two-word line per set with
// a combinational read port and a synchronous line-fill / single-word write port.
module cache_way_array
    import cache_ctrl_assoc_pkg::*;
#(
    parameter int DEPTH    = SETS,
    parameter int TAG_BITS = TAG_W,
    parameter int DATA_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(DEPTH)-1:0]   index,
    output logic                       valid,
    output logic [TAG_BITS-1:0]        tag,
    output logic [2*DATA_W-1:0]        line,
    input  logic                       fill_en,
    input  logic [TAG_BITS-1:0]        fill_tag,
    input  logic [2*DATA_W-1:0]        fill_line,
    input  logic                       word_en,
    input  logic                       word_sel,
    input  logic [DATA_W-1:0]          word_data
);
    logic [DEPTH-1:0]    valid_q;
    logic [TAG_BITS-1:0] tags [DEPTH];
    logic [2*DATA_W-1:0] data [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid_q <= '0;
        else if (fill_en)
            valid_q[index] <= 1'b1;
    end

    // Payload is left unreset so it can map onto plain RAM; valid gates it
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[index] <= fill_tag;
            data[index] <= fill_line;
        end else if (word_en) begin
            if (word_sel)
                data[index][2*DATA_W-1:DATA_W] <= word_data;
            else
                data[index][DATA_W-1:0] <= word_data;
        end
    end

    assign valid = valid_q[index];
    assign tag   = tags[index];
    assign line  = data[index];
endmodule

// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: write-through, no-write-allocate, 1/2-way set-associative
// data cache with LRU replacement and 64-bit line fill from the SRAM controller.
module cache_ctrl_assoc
    import cache_ctrl_assoc_pkg::*;
#(
    parameter int ADDR_BASE = 1024,
    parameter int SET_BITS  = 6,
    parameter int WAYS      = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    input  logic [2*DATA_W-1:0] sram_rdata,
    input  logic                sram_ready,
    output logic [ADDR_W-1:0]   sram_address,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic                sram_read_en,
    output logic                sram_write_en
);
    localparam int TAG_BITS = tag_width(ADDR_W, SET_BITS);
    localparam int DEPTH    = 1 << SET_BITS;

    if (!ways_legal(WAYS)) begin : g_bad_ways
        $error("cache_ctrl_assoc: WAYS must be 1 or 2");
    end

    logic [1:0]          state;
    logic                idle;
    logic [TAG_BITS-1:0] tag, c_tag;
    logic [SET_BITS-1:0] idx, c_idx, sel_idx;
    logic                word, c_word;
    logic [1:0]          byte_unused;
    logic [WAYS-1:0]     way_valid, hit_vec, fill_vec, word_vec;
    logic [TAG_BITS-1:0] way_tag [WAYS];
    logic [2*DATA_W-1:0] way_line [WAYS];
    logic [2*DATA_W-1:0] hit_line;
    logic                hit, hit_w, victim, lru_way;

    assign {tag, idx, word, byte_unused} = address - ADDR_W'(ADDR_BASE);
    assign idle    = state == IDLE;
    assign sel_idx = idle ? idx : c_idx;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign hit_vec[g]  = way_valid[g] && way_tag[g] == tag;
        assign fill_vec[g] = state == READ_MISS && sram_ready && victim == 1'(g);
        assign word_vec[g] = idle && mem_w_en && !mem_r_en && hit_vec[g];
        cache_way_array #(
            .DEPTH(DEPTH), .TAG_BITS(TAG_BITS), .DATA_W(DATA_W)
        ) u_way (
            .clk(clk), .rst(rst), .index(sel_idx),
            .valid(way_valid[g]), .tag(way_tag[g]), .line(way_line[g]),
            .fill_en(fill_vec[g]), .fill_tag(c_tag), .fill_line(sram_rdata),
            .word_en(word_vec[g]), .word_sel(word), .word_data(wdata)
        );
    end

    assign hit      = |hit_vec;
    assign hit_w    = (WAYS == 2) && hit_vec[WAYS-1];
    assign hit_line = way_line[hit_w];
    // Fill the first invalid way, otherwise the least recently used one
    assign victim   = (WAYS == 2) && way_valid[0] && (!way_valid[WAYS-1] || lru_way);

    if (WAYS == 2) begin : g_lru
        logic [DEPTH-1:0] lru;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                lru <= '0;
            else if (fill_vec != '0)
                lru[c_idx] <= !victim;
            else if (idle && hit && (mem_r_en || mem_w_en))
                lru[idx] <= !hit_w;
        end
        assign lru_way = lru[c_idx];
    end else begin : g_no_lru
        assign lru_way = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            sram_address <= '0;
            sram_wdata   <= '0;
            c_tag        <= '0;
            c_idx        <= '0;
            c_word       <= 1'b0;
        end else if (idle && (mem_r_en ? !hit : mem_w_en)) begin
            state        <= mem_r_en ? READ_MISS : WRITE_THRU;
            sram_address <= address;
            sram_wdata   <= mem_r_en ? sram_wdata : wdata;
            c_tag        <= tag;
            c_idx        <= idx;
            c_word       <= word;
        end else if (!idle && sram_ready) begin
            state <= IDLE;
        end
    end

    assign sram_read_en  = state == READ_MISS;
    assign sram_write_en = state == WRITE_THRU;
    assign ready         = idle ? (mem_r_en ? hit : !mem_w_en) : sram_ready;

    // Miss data is forwarded straight from the SRAM bus in the completion cycle
    always_comb begin
        rdata = !mem_r_en ? '0
              : idle ? (hit ? (word ? hit_line[2*DATA_W-1:DATA_W] : hit_line[DATA_W-1:0]) : '0)
              : (sram_read_en && sram_ready) ? (c_word ? sram_rdata[2*DATA_W-1:DATA_W] : sram_rdata[DATA_W-1:0])
              : '0;
    end
endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// tb_cache_ctrl_assoc: directed bench for a 2-way and a 1-way instance, checked
// every cycle against a recency-list cache model kept in the bench.
module tb_cache_ctrl_assoc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] address [2], wdata [2], rdata [2], sram_address [2], sram_wdata [2];
    logic        mem_r_en [2], mem_w_en [2], ready [2], sram_ready [2];
    logic        sram_read_en [2], sram_write_en [2];
    logic [63:0] sram_rdata [2];

    cache_ctrl_assoc #(.WAYS(2)) dut2 (
        .clk(clk), .rst(rst), .address(address[0]), .wdata(wdata[0]),
        .mem_r_en(mem_r_en[0]), .mem_w_en(mem_w_en[0]), .rdata(rdata[0]), .ready(ready[0]),
        .sram_rdata(sram_rdata[0]), .sram_ready(sram_ready[0]), .sram_address(sram_address[0]),
        .sram_wdata(sram_wdata[0]), .sram_read_en(sram_read_en[0]), .sram_write_en(sram_write_en[0])
    );

    cache_ctrl_assoc #(.WAYS(1)) dut1 (
        .clk(clk), .rst(rst), .address(address[1]), .wdata(wdata[1]),
        .mem_r_en(mem_r_en[1]), .mem_w_en(mem_w_en[1]), .rdata(rdata[1]), .ready(ready[1]),
        .sram_rdata(sram_rdata[1]), .sram_ready(sram_ready[1]), .sram_address(sram_address[1]),
        .sram_wdata(sram_wdata[1]), .sram_read_en(sram_read_en[1]), .sram_write_en(sram_write_en[1])
    );

    int tests = 0;
    int fails = 0;
    bit chk = 0;
    int sel = 0;
    logic        e_ready, e_rd, e_wr;
    logic [31:0] e_rdata, e_addr, e_wd;

    // Model: per instance and set, a list of lines ordered most-recent first
    int          ways_of [2] = '{2, 1};
    int          m_cnt  [2][64];
    logic [22:0] m_tag  [2][64][2];
    logic [63:0] m_line [2][64][2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("ready", ready[sel], e_ready);
            check("rdata", rdata[sel], e_rdata);
            check("sram_read_en", sram_read_en[sel], e_rd);
            check("sram_write_en", sram_write_en[sel], e_wr);
            if (e_rd || e_wr) check("sram_address", sram_address[sel], e_addr);
            if (e_wr) check("sram_wdata", sram_wdata[sel], e_wd);
        end
    end

    function automatic logic [31:0] pick(input logic [63:0] l, input bit w);
        return w ? l[63:32] : l[31:0];
    endfunction

    task automatic decode(input logic [31:0] a, output int s, output logic [22:0] t, output bit w);
        logic [31:0] o;
        o = a - 32'd1024;
        s = int'(o[8:3]);
        t = o[31:9];
        w = o[2];
    endtask

    function automatic int find(input int d, input int s, input logic [22:0] t);
        for (int i = 0; i < m_cnt[d][s]; i++)
            if (m_tag[d][s][i] == t) return i;
        return -1;
    endfunction

    task automatic touch(input int d, input int s, input int p);
        logic [22:0] t;
        logic [63:0] l;
        t = m_tag[d][s][p];
        l = m_line[d][s][p];
        for (int i = p; i > 0; i--) begin
            m_tag[d][s][i]  = m_tag[d][s][i-1];
            m_line[d][s][i] = m_line[d][s][i-1];
        end
        m_tag[d][s][0]  = t;
        m_line[d][s][0] = l;
    endtask

    task automatic fill(input int d, input int s, input logic [22:0] t, input logic [63:0] l);
        int n;
        n = (m_cnt[d][s] < ways_of[d]) ? m_cnt[d][s] + 1 : ways_of[d];
        for (int i = n - 1; i > 0; i--) begin
            m_tag[d][s][i]  = m_tag[d][s][i-1];
            m_line[d][s][i] = m_line[d][s][i-1];
        end
        m_tag[d][s][0]  = t;
        m_line[d][s][0] = l;
        m_cnt[d][s]     = n;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 64; s++) m_cnt[d][s] = 0;
    endtask

    task automatic idle_exp();
        e_ready = 1'b1;
        e_rdata = '0;
        e_rd    = 1'b0;
        e_wr    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One memory-stage access; hand_hit/hand_rd pin the model on reads
    task automatic req(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [63:0] line,
                       input bit hand_hit, input logic [31:0] hand_rd);
        int s, p;
        logic [22:0] t;
        bit wb;
        decode(a, s, t, wb);
        p = find(d, s, t);
        sel = d;
        address[d] = a; wdata[d] = wd; mem_r_en[d] = r; mem_w_en[d] = w; sram_rdata[d] = line;
        if (r) check("model_hit", p >= 0, hand_hit);
        if (r && p >= 0) begin
            e_ready = 1'b1; e_rd = 1'b0; e_wr = 1'b0;
            e_rdata = pick(m_line[d][s][p], wb);
            check("model_rdata", e_rdata, hand_rd);
            cyc();
            touch(d, s, p);
        end else if (r || w) begin
            e_ready = 1'b0; e_rdata = '0; e_rd = 1'b0; e_wr = 1'b0;
            e_addr = a; e_wd = wd;
            cyc();
            for (int k = 0; k < lat; k++) begin
                sram_ready[d] = (k == lat - 1);
                e_ready = sram_ready[d];
                e_rd = r;
                e_wr = !r;
                e_rdata = (r && sram_ready[d]) ? pick(line, wb) : '0;
                if (r && sram_ready[d]) check("model_rdata", e_rdata, hand_rd);
                cyc();
            end
            sram_ready[d] = 1'b0;
            if (r) fill(d, s, t, line);
            else if (p >= 0) begin
                m_line[d][s][p] = wb ? {wd, m_line[d][s][p][31:0]} : {m_line[d][s][p][63:32], wd};
                touch(d, s, p);
            end
        end else begin
            idle_exp();
            cyc();
        end
        mem_r_en[d] = 1'b0;
        mem_w_en[d] = 1'b0;
        idle_exp();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            address[d] = '0; wdata[d] = '0; mem_r_en[d] = 1'b0; mem_w_en[d] = 1'b0;
            sram_ready[d] = 1'b0; sram_rdata[d] = '0;
        end
        clear_model();
        idle_exp();
        e_addr = '0;
        e_wd = '0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", ready[d], 1'b1);
            check("reset_rdata", rdata[d], 32'h0);
            check("reset_read_en", sram_read_en[d], 1'b0);
            check("reset_write_en", sram_write_en[d], 1'b0);
            check("reset_sram_address", sram_address[d], 32'h0);
            check("reset_sram_wdata", sram_wdata[d], 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk = 1'b1;
        cyc();

        req(0, 1, 0, 1028, 0, 3, 64'hBBBB_BBBB_AAAA_AAAA, 0, 32'hBBBB_BBBB);
        req(0, 1, 0, 1028, 0, 1, 64'h0, 1, 32'hBBBB_BBBB);
        req(0, 0, 1, 1024, 32'h1234_5678, 2, 64'h0, 0, 0);
        req(0, 1, 0, 1024, 0, 1, 64'h0, 1, 32'h1234_5678);
        req(0, 1, 1, 1028, 32'hDEAD_BEEF, 2, 64'h0, 1, 32'hBBBB_BBBB);
        sram_ready[0] = 1'b1;
        cyc();
        sram_ready[0] = 1'b0;
        req(0, 0, 1, 2048, 32'h5555_0000, 1, 64'h0, 0, 0);
        req(0, 1, 0, 2048, 0, 2, 64'hCCCC_CCC1_CCCC_CCC0, 0, 32'hCCCC_CCC0);
        req(0, 1, 0, 1024, 0, 1, 64'h0, 1, 32'h1234_5678);
        req(0, 1, 0, 1536, 0, 2, 64'hDDDD_DDD1_DDDD_DDD0, 0, 32'hDDDD_DDD0);
        req(0, 1, 0, 1024, 0, 1, 64'h0, 1, 32'h1234_5678);
        req(0, 1, 0, 2048, 0, 1, 64'hCCCC_CCC1_CCCC_CCC0, 0, 32'hCCCC_CCC0);
        req(0, 1, 0, 1024, 0, 1, 64'h0, 1, 32'h1234_5678);
        req(0, 1, 0, 1536, 0, 3, 64'hDDDD_DDD1_DDDD_DDD0, 0, 32'hDDDD_DDD0);

        req(1, 1, 0, 1024, 0, 2, 64'hEEEE_EEE1_EEEE_EEE0, 0, 32'hEEEE_EEE0);
        req(1, 1, 0, 1536, 0, 1, 64'hDDDD_DDD1_DDDD_DDD0, 0, 32'hDDDD_DDD0);
        req(1, 1, 0, 1024, 0, 1, 64'hEEEE_EEE1_EEEE_EEE0, 0, 32'hEEEE_EEE0);
        req(1, 1, 0, 1028, 0, 1, 64'h0, 1, 32'hEEEE_EEE1);

        // Reset in the middle of a read miss on the 2-way instance
        sel = 0;
        address[0] = 1036;
        mem_r_en[0] = 1'b1;
        e_ready = 1'b0; e_rdata = '0; e_rd = 1'b0; e_wr = 1'b0;
        cyc();
        e_rd = 1'b1;
        e_addr = 1036;
        cyc();
        cyc();
        chk = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("rst_read_en", sram_read_en[0], 1'b0);
        check("rst_ready", ready[0], 1'b0);
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_sram_address", sram_address[0], 32'h0);
        mem_r_en[0] = 1'b0;
        cyc();
        rst = 1'b1;
        clear_model();
        idle_exp();
        chk = 1'b1;
        cyc();
        req(0, 1, 0, 1028, 0, 2, 64'h1111_2222_3333_4444, 0, 32'h1111_2222);
        req(1, 1, 0, 1028, 0, 1, 64'h1111_2222_3333_4444, 0, 32'h1111_2222);
        cyc();
        chk = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
